uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, 8N1, LSB first. It is the receive-side counterpart of the team's `uart_tx` and consumes the serial line that `uart_tx` drives (loopback, or an external host).
- Synchronises the asynchronous `rx` input.
- Validates the start bit and samples each bit at mid-period.
- Checks the stop bit.
- Presents each received byte with a one-cycle valid strobe.
- Uses the same `CLK_FREQ`/`BAUD_RATE` parameterisation as `uart_tx`, so one parameter set serves both directions.

Parameters:
- `CLK_FREQ`, 25000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in baud.
- Derived (localparam) `DIV` = `CLK_FREQ`/`BAUD_RATE` (integer divide), clocks per bit.
- Derived (localparam) `HALF` = `DIV`/2.
- Constraint: `DIV` ≥ 4; counter width holds `DIV`-1.

Ports:
- `clk`, input, 1, system clock; all logic on rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `rx`, input, 1, asynchronous serial line; idles high.
- `data`, output, 8, last correctly framed byte; holds until the next good frame.
- `valid`, output, 1, one-cycle strobe: `data` updated this cycle.
- `frame_err`, output, 1, one-cycle strobe: stop bit sampled low.
- `busy`, output, 1, high whenever the state is not IDLE.

Behaviour:
- Synchroniser: two flops, `rx` → `rx_s1` → `rx_s`; both reset to 1. All decisions use `rx_s` only.
- Reset (`rst`=1 at an edge), from any state including mid-frame:
  - state=IDLE; counter=0; bit index=0; shift register=0.
  - `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
  - A frame in progress is discarded with no strobe.
- Counter semantics: in every non-IDLE state, counter increments each cycle unless that state's compare hits, in which case it loads 0.
- IDLE:
  - If `rx_s`=0: counter←0, go to START.
  - Else stay.
- START, evaluated at counter==`HALF`:
  - If `rx_s`=1: false start (glitch), go to IDLE; no strobe.
  - Else: counter←0, bit index←0, go to DATA.
- DATA, evaluated at counter==`DIV`-1:
  - shift←{`rx_s`, shift[7:1]} (LSB first); bit index +1.
  - After the 8th sample (index==7), go to STOP.
- STOP, evaluated at counter==`DIV`-1:
  - `rx_s`=1: `data`←shift, `valid`=1 for exactly one cycle, go to IDLE.
  - `rx_s`=0: `frame_err`=1 for exactly one cycle, `data` unchanged, go to BREAK.
- BREAK: wait until `rx_s`=1, then go to IDLE. This prevents a line held low from retriggering frames.
- `valid` and `frame_err` are registered, default 0 each cycle, and never high together.
- Latency: let E0 be the first edge at which `rx` is sampled 0 into `rx_s1`.
  - `valid`/`frame_err` go high at edge E0+3+`HALF`+9·`DIV`.
  - Data bit k is sampled at edge E0+2+`HALF`+(k+1)·`DIV`.
- Back-to-back frames: a start bit that begins immediately after a 1-bit-wide stop bit is detected. The receiver returns to IDLE about `HALF` clocks before the stop bit ends.
- `busy` is combinational from state (≠IDLE). It is 0 in IDLE only; BREAK counts as busy.
- No input FIFO and no overrun detection: consumers must take `data` within one frame time after `valid`.

Test Plan:
All scenarios use `CLK_FREQ`=1000, `BAUD_RATE`=100, so `DIV`=10 and `HALF`=5.
1. Reset check: hold `rst` high 3 cycles, `rx`=1 → `data`=00, `valid`=0, `frame_err`=0, `busy`=0. Remain so for 50 idle cycles.
2. Single frame: drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop), each bit 10 clocks, `rx` falling sampled at E0 → `valid`=1 at edge E98 only, `data`=A5, `frame_err` never 1.
3. Glitch: `rx` low for 3 clocks then high → `busy` rises, then falls after the START check; no `valid` or `frame_err`.
4. Framing error then break: send 0x3C with stop bit low, then hold low 50 clocks → one `frame_err` pulse, `data` keeps previous value, `busy` stays 1 until `rx` goes high. A following good 0x3C frame → `valid`, `data`=3C.
5. Back-to-back: 0x00 then 0xFF with no idle gap (one stop bit each) → two `valid` pulses exactly 100 clocks apart, `data`=00 then FF.
6. Reset mid-frame: assert `rst` for 1 cycle during data bit 4 of a 0x55 frame → IDLE, no strobe for that frame. A subsequent 0x81 frame is received correctly.
   - Also required: loopback with `uart_tx` at the default parameters sending 0x00, 0x5A, 0xFF → all three received in order.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, stop-bit check.
// valid/frame_err strobe HALF+9*DIV+3 clocks after the falling start edge; no backpressure (one-byte holding register).
module uart_rx #(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx_s1_q, rx_s1_d;
    logic            rx_s_q, rx_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            rx_s1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            rx_s1_q <= rx_s1_d;
            rx_s_q  <= rx_s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        rx_s1_d = rx;
        rx_s_d  = rx_s1_q;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line mid start bit so short glitches are rejected.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                // A line held low must return high before another start is accepted.
                cnt_d = cnt_q + 1'b1;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule
